// File: rtl/tone_sequencer.sv
// Sequences the 392 Hz / 110 Hz tone enables from one-cycle pass/fail requests.
// Optional build macro TONE_SEQ_PREEMPT_EN lets fail_req abort a playing pass pattern.
module tone_sequencer #(
    parameter int TICK_DIV   = 125000,
    parameter int BEEP_TICKS = 150,
    parameter int GAP_TICKS  = 100,
    parameter int FAIL_TICKS = 800,
    parameter int PASS_BEEPS = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pass_req,
    input  logic fail_req,
    output logic busy,
    output logic done,
    output logic en392,
    output logic en110
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        P_ON  = 2'd1,
        P_GAP = 2'd2,
        F_ON  = 2'd3
    } state_t;

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [15:0]   BEEP_LAST  = 16'(BEEP_TICKS - 1);
    localparam logic [15:0]   GAP_LAST   = 16'(GAP_TICKS - 1);
    localparam logic [15:0]   FAIL_LAST  = 16'(FAIL_TICKS - 1);
    localparam logic [3:0]    BEEPS_LAST = 4'(PASS_BEEPS - 1);

    state_t        state_r;
    state_t        state_next_s;
    logic [PW-1:0] presc_r;
    logic [PW-1:0] presc_next_s;
    logic [PW-1:0] presc_adv_s;
    logic [15:0]   tick_r;
    logic [15:0]   tick_next_s;
    logic [15:0]   tick_adv_s;
    logic [3:0]    beep_r;
    logic [3:0]    beep_next_s;
    logic          tick_end_s;
    logic          done_next_s;
    logic          busy_r;
    logic          done_r;
    logic          en392_r;
    logic          en110_r;

    assign busy  = busy_r;
    assign done  = done_r;
    assign en392 = en392_r;
    assign en110 = en110_r;

    // Free-running time base within a state: prescaler wraps into the tick counter.
    always_comb begin
        tick_end_s = (presc_r == PRESC_LAST);
        if (tick_end_s) begin
            presc_adv_s = {PW{1'b0}};
            tick_adv_s  = tick_r + 16'd1;
        end else begin
            presc_adv_s = presc_r + PW'(1);
            tick_adv_s  = tick_r;
        end
    end

    // Next-state logic; every state change clears the time base so durations are exact.
    always_comb begin
        state_next_s = state_r;
        presc_next_s = presc_adv_s;
        tick_next_s  = tick_adv_s;
        beep_next_s  = beep_r;
        done_next_s  = 1'b0;
        case (state_r)
            IDLE: begin
                presc_next_s = {PW{1'b0}};
                tick_next_s  = 16'd0;
                beep_next_s  = 4'd0;
                if (fail_req) begin
                    state_next_s = F_ON;
                end else if (pass_req) begin
                    state_next_s = P_ON;
                end else begin
                    state_next_s = IDLE;
                end
            end
            P_ON: begin
`ifdef TONE_SEQ_PREEMPT_EN
                if (fail_req) begin
                    state_next_s = F_ON;
                    presc_next_s = {PW{1'b0}};
                    tick_next_s  = 16'd0;
                    beep_next_s  = 4'd0;
                end else
`endif
                if (tick_end_s && (tick_r == BEEP_LAST)) begin
                    presc_next_s = {PW{1'b0}};
                    tick_next_s  = 16'd0;
                    if (beep_r == BEEPS_LAST) begin
                        state_next_s = IDLE;
                        beep_next_s  = 4'd0;
                        done_next_s  = 1'b1;
                    end else begin
                        state_next_s = P_GAP;
                        beep_next_s  = beep_r + 4'd1;
                    end
                end else begin
                    state_next_s = P_ON;
                end
            end
            P_GAP: begin
`ifdef TONE_SEQ_PREEMPT_EN
                if (fail_req) begin
                    state_next_s = F_ON;
                    presc_next_s = {PW{1'b0}};
                    tick_next_s  = 16'd0;
                    beep_next_s  = 4'd0;
                end else
`endif
                if (tick_end_s && (tick_r == GAP_LAST)) begin
                    state_next_s = P_ON;
                    presc_next_s = {PW{1'b0}};
                    tick_next_s  = 16'd0;
                end else begin
                    state_next_s = P_GAP;
                end
            end
            F_ON: begin
                if (tick_end_s && (tick_r == FAIL_LAST)) begin
                    state_next_s = IDLE;
                    presc_next_s = {PW{1'b0}};
                    tick_next_s  = 16'd0;
                    done_next_s  = 1'b1;
                end else begin
                    state_next_s = F_ON;
                end
            end
            default: begin
                state_next_s = IDLE;
                presc_next_s = {PW{1'b0}};
                tick_next_s  = 16'd0;
                beep_next_s  = 4'd0;
            end
        endcase
    end

    // State, counters and outputs; outputs decode the next state so they change on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            presc_r <= {PW{1'b0}};
            tick_r  <= 16'd0;
            beep_r  <= 4'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            en392_r <= 1'b0;
            en110_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            presc_r <= presc_next_s;
            tick_r  <= tick_next_s;
            beep_r  <= beep_next_s;
            busy_r  <= (state_next_s != IDLE);
            done_r  <= done_next_s;
            en392_r <= (state_next_s == P_ON);
            en110_r <= (state_next_s == F_ON);
        end
    end

endmodule
